// File: rtl/alarm_rtc_core.sv
// Time-of-day clock with programmable alarm, ring/snooze/dismiss FSM and an Avalon-MM slave.
// Optional macro ALARM_RTC_WEEKDAY_EN adds a day-of-week counter and the DAY_MASK register.
module alarm_rtc_core #(
   parameter int TICKS_PER_SEC  = 1,
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_in,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        alarm_out
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

   state_t          state;
   logic [4:0]      hours, alarm_h, next_hour, cmp_hour;
   logic [5:0]      mins, secs, alarm_m, next_min, snooze_left;
   logic [7:0]      ring_cnt;
   logic [PW-1:0]   presc;
   logic            run, alarm_en, irq_sec_en, irq_alarm_en, sec_flag;
   logic            wr, rd, time_wr, presc_last, sec_pulse, min_carry, hr_carry;
   logic            match, dismiss, snooze, day_ok;
   logic [15:0]     rd_mux;
   logic            unused_wd;
`ifdef ALARM_RTC_WEEKDAY_EN
   logic [2:0]      day, next_day, cmp_day;
   logic [6:0]      day_mask;
`endif

   function automatic logic [5:0] clamp60(input logic [5:0] v);
      return (v > 6'd59) ? 6'd0 : v;
   endfunction

   function automatic logic [4:0] clamp24(input logic [4:0] v);
      return (v > 5'd23) ? 5'd0 : v;
   endfunction

   assign wr         = chipselect & ~write_n;
   assign rd         = chipselect & write_n;
   assign time_wr    = wr & ((address == 3'd2) | (address == 3'd3));
   assign presc_last = (presc == PW'(TICKS_PER_SEC - 1));
   // A time write in the same cycle swallows the second pulse entirely.
   assign sec_pulse  = run & tick_in & presc_last & ~time_wr;
   assign min_carry  = sec_pulse & (secs == 6'd59);
   assign hr_carry   = min_carry & (mins == 6'd59);
   assign next_min   = (mins == 6'd59) ? 6'd0 : mins + 6'd1;
   assign next_hour  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
   assign cmp_hour   = hr_carry ? next_hour : hours;
   assign dismiss    = wr & (address == 3'd0) & writedata[0];
   assign snooze     = wr & (address == 3'd1) & writedata[4];
   assign unused_wd  = ^{writedata[15:13], writedata[7:6]};

`ifdef ALARM_RTC_WEEKDAY_EN
   assign next_day = (day == 3'd6) ? 3'd0 : day + 3'd1;
   assign cmp_day  = (hr_carry && hours == 5'd23) ? next_day : day;
   assign day_ok   = day_mask[cmp_day];
`else
   assign day_ok   = 1'b1;
`endif

   assign match = min_carry & alarm_en & day_ok & (cmp_hour == alarm_h) & (next_min == alarm_m);
   assign irq   = (sec_flag & irq_sec_en) | (alarm_out & irq_alarm_en);

   always_comb begin
      rd_mux = 16'd0;
      case (address)
         3'd0: rd_mux = {14'd0, sec_flag, alarm_out};
         3'd1: rd_mux = {12'd0, irq_alarm_en, irq_sec_en, alarm_en, run};
`ifdef ALARM_RTC_WEEKDAY_EN
         3'd2: rd_mux = {day, hours, 2'd0, mins};
         3'd6: rd_mux = {9'd0, day_mask};
`else
         3'd2: rd_mux = {3'd0, hours, 2'd0, mins};
`endif
         3'd3: rd_mux = {10'd0, secs};
         3'd4: rd_mux = {3'd0, alarm_h, 2'd0, alarm_m};
         3'd5: rd_mux = {10'd0, snooze_left};
         default: rd_mux = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hours <= '0; mins <= '0; secs <= '0; alarm_h <= '0; alarm_m <= '0;
         presc <= '0; sec_flag <= 1'b0; readdata <= '0;
         {irq_alarm_en, irq_sec_en, alarm_en, run} <= 4'd0;
`ifdef ALARM_RTC_WEEKDAY_EN
         day <= '0; day_mask <= 7'h7F;
`endif
      end else begin
         if (time_wr)
            presc <= '0;
         else if (run && tick_in)
            presc <= presc_last ? '0 : presc + PW'(1);

         if (sec_pulse) begin
            secs <= (secs == 6'd59) ? 6'd0 : secs + 6'd1;
            if (min_carry) mins <= next_min;
            if (hr_carry) hours <= next_hour;
`ifdef ALARM_RTC_WEEKDAY_EN
            if (hr_carry && hours == 5'd23) day <= next_day;
`endif
         end

         if (wr) begin
            case (address)
               3'd1: {irq_alarm_en, irq_sec_en, alarm_en, run} <= writedata[3:0];
               3'd2: begin
                  hours <= clamp24(writedata[12:8]);
                  mins  <= clamp60(writedata[5:0]);
`ifdef ALARM_RTC_WEEKDAY_EN
                  day   <= (writedata[15:13] == 3'd7) ? 3'd0 : writedata[15:13];
`endif
               end
               3'd3: secs <= clamp60(writedata[5:0]);
               3'd4: begin
                  alarm_h <= clamp24(writedata[12:8]);
                  alarm_m <= clamp60(writedata[5:0]);
               end
`ifdef ALARM_RTC_WEEKDAY_EN
               3'd6: day_mask <= writedata[6:0];
`endif
               default: ;
            endcase
         end

         // A new second beats a simultaneous clear so no event is lost.
         if (wr && address == 3'd0 && writedata[1]) sec_flag <= 1'b0;
         if (sec_pulse) sec_flag <= 1'b1;

         if (rd) readdata <= rd_mux;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE; alarm_out <= 1'b0; ring_cnt <= '0; snooze_left <= '0;
      end else if (!alarm_en) begin
         state <= IDLE; alarm_out <= 1'b0; snooze_left <= '0;
      end else begin
         case (state)
            IDLE: if (match) begin
               state <= RINGING; alarm_out <= 1'b1; ring_cnt <= 8'(RING_TIMEOUT_S);
            end
            RINGING: begin
               if (dismiss) begin
                  state <= IDLE; alarm_out <= 1'b0;
               end else if (snooze) begin
                  state <= SNOOZED; alarm_out <= 1'b0; snooze_left <= 6'(SNOOZE_MIN);
               end else if (sec_pulse) begin
                  if (ring_cnt <= 8'd1) begin
                     state <= IDLE; alarm_out <= 1'b0; ring_cnt <= '0;
                  end else
                     ring_cnt <= ring_cnt - 8'd1;
               end
            end
            SNOOZED: begin
               if (dismiss) begin
                  state <= IDLE; snooze_left <= '0;
               end else if (min_carry) begin
                  if (snooze_left <= 6'd1) begin
                     state <= RINGING; alarm_out <= 1'b1; snooze_left <= '0;
                     ring_cnt <= 8'(RING_TIMEOUT_S);
                  end else
                     snooze_left <= snooze_left - 6'd1;
               end
            end
            default: begin
               state <= IDLE; alarm_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_rtc_core.sv
// Bench for alarm_rtc_core: directed scenarios then random traffic against a
// seconds-of-day reference model.
module tb_alarm_rtc_core;

   localparam int TPS  = 2;
   localparam int SNZ  = 2;
   localparam int RING = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick_in = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'd0;
   logic [15:0] readdata;
   logic        irq, alarm_out;

   int total = 0;
   int bad = 0;

   // reference model: time as seconds since midnight, alarm as minutes since midnight
   int          m_tod, m_alarm_min, m_ticks, m_state, m_ring, m_snz;
   bit          m_run, m_aen, m_isec, m_ialarm, m_flag;
   logic [15:0] m_rd;

   alarm_rtc_core #(.TICKS_PER_SEC(TPS), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_S(RING)) dut (
      .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .irq(irq), .alarm_out(alarm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tod = 0; m_alarm_min = 0; m_ticks = 0; m_state = 0; m_ring = 0; m_snz = 0;
      m_run = 0; m_aen = 0; m_isec = 0; m_ialarm = 0; m_flag = 0; m_rd = 16'd0;
   endtask

   function automatic logic [15:0] model_read(input int a);
      case (a)
         0: return 16'({m_flag, m_state == 1});
         1: return 16'({m_ialarm, m_isec, m_aen, m_run});
         2: return 16'((m_tod / 3600) * 256 + (m_tod / 60) % 60);
         3: return 16'(m_tod % 60);
         4: return 16'((m_alarm_min / 60) * 256 + m_alarm_min % 60);
         5: return 16'(m_snz);
         default: return 16'd0;
      endcase
   endfunction

   function automatic bit model_irq();
      return (m_flag && m_isec) || (m_state == 1 && m_ialarm);
   endfunction

   task automatic model_step(input bit t, input bit w, input int a, input logic [15:0] d);
      bit time_wr, pulse, min_carry, match, dismiss, snooze, clr;
      int h, mi;
      time_wr   = w && (a == 2 || a == 3);
      dismiss   = w && a == 0 && d[0];
      clr       = w && a == 0 && d[1];
      snooze    = w && a == 1 && d[4];
      pulse     = m_run && t && (m_ticks == TPS - 1) && !time_wr;
      min_carry = 0;
      match     = 0;
      if (time_wr) m_ticks = 0;
      else if (m_run && t) m_ticks = (m_ticks + 1) % TPS;
      if (pulse) begin
         m_tod     = (m_tod + 1) % 86400;
         min_carry = (m_tod % 60 == 0);
         match     = min_carry && m_aen && (m_tod / 60 == m_alarm_min);
      end
      if (!m_aen) begin
         m_state = 0; m_snz = 0;
      end else if (m_state == 0) begin
         if (match) begin m_state = 1; m_ring = RING; end
      end else if (m_state == 1) begin
         if (dismiss) m_state = 0;
         else if (snooze) begin m_state = 2; m_snz = SNZ; end
         else if (pulse) begin
            m_ring--;
            if (m_ring <= 0) begin m_state = 0; m_ring = 0; end
         end
      end else begin
         if (dismiss) begin m_state = 0; m_snz = 0; end
         else if (min_carry) begin
            m_snz--;
            if (m_snz <= 0) begin m_state = 1; m_snz = 0; m_ring = RING; end
         end
      end
      if (w) begin
         h  = int'(d[12:8]); if (h > 23) h = 0;
         mi = int'(d[5:0]);  if (mi > 59) mi = 0;
         case (a)
            1: {m_ialarm, m_isec, m_aen, m_run} = d[3:0];
            2: m_tod = h * 3600 + mi * 60 + m_tod % 60;
            3: m_tod = (m_tod / 60) * 60 + mi;
            4: m_alarm_min = h * 60 + mi;
            default: ;
         endcase
      end
      if (pulse) m_flag = 1;
      else if (clr) m_flag = 0;
   endtask

   task automatic cyc(input bit t, input bit cs, input bit wn, input int a, input logic [15:0] d);
      tick_in = t; chipselect = cs; write_n = wn; address = 3'(a); writedata = d;
      if (cs && wn) m_rd = model_read(a);
      @(posedge clk);
      model_step(t, cs && !wn, a, d);
      #1;
      tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      chk("readdata", readdata, m_rd);
      chk("alarm_out", 16'(alarm_out), 16'(m_state == 1));
      chk("irq", 16'(irq), 16'(model_irq()));
   endtask

   task automatic wr(input int a, input logic [15:0] d); cyc(0, 1, 0, a, d); endtask
   task automatic rd(input int a); cyc(0, 1, 1, a, 16'd0); endtask
   task automatic tk(); cyc(1, 0, 1, 0, 16'd0); endtask

   initial begin
      int r, a;
      logic [15:0] ctl;
      model_reset();
      #12;
      chk("reset_readdata", readdata, 16'd0);
      chk("reset_irq", 16'(irq), 16'd0);
      chk("reset_alarm_out", 16'(alarm_out), 16'd0);
      reset_n = 1'b1;
      @(negedge clk);
      rd(2); chk("reset_time_hm", readdata, 16'h0000);

      // midnight rollover
      wr(2, 16'h173B); wr(3, 16'h003B); wr(1, 16'h0001);
      tk(); tk();
      rd(2); chk("rollover_hm", readdata, 16'h0000);
      rd(3); chk("rollover_s", readdata, 16'h0000);
      rd(0); chk("rollover_flag", readdata, 16'h0002);

      // alarm match at 07:30:00
      wr(4, 16'h071E); wr(2, 16'h071D); wr(3, 16'h003B); wr(1, 16'h000B);
      tk(); tk();
      chk("ring_alarm_out", 16'(alarm_out), 16'd1);
      chk("ring_irq", 16'(irq), 16'd1);

      // snooze, then re-ring after two minutes
      wr(1, 16'h001B);
      chk("snooze_alarm_out", 16'(alarm_out), 16'd0);
      rd(5); chk("snooze_left", readdata, 16'd2);
      for (int i = 0; i < 240; i++) tk();
      chk("rering_alarm_out", 16'(alarm_out), 16'd1);

      // unattended ring times out
      for (int i = 0; i < 6; i++) tk();
      chk("timeout_alarm_out", 16'(alarm_out), 16'd0);
      chk("timeout_irq", 16'(irq), 16'd0);

      // out-of-range seconds, and write beating a same-cycle second pulse
      wr(3, 16'h003F);
      rd(3); chk("sec_clamp", readdata, 16'd0);
      wr(0, 16'h0002);
      tk();
      cyc(1, 1, 0, 3, 16'd10);
      rd(3); chk("write_wins_s", readdata, 16'd10);
      rd(0); chk("write_wins_flag", readdata, 16'd0);

      // reset while ringing
      wr(2, 16'h071D); wr(3, 16'h003B);
      tk(); tk();
      chk("pre_reset_ring", 16'(alarm_out), 16'd1);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_alarm_out", 16'(alarm_out), 16'd0);
      chk("rst_readdata", readdata, 16'd0);
      chk("rst_irq", 16'(irq), 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(2); chk("rst_time_hm", readdata, 16'h0000);
      rd(3); chk("rst_time_s", readdata, 16'h0000);

      // random traffic
      wr(2, 16'(($urandom_range(0, 23) << 8) | $urandom_range(0, 59)));
      wr(3, 16'($urandom_range(40, 59)));
      wr(4, 16'((((m_tod / 60 + 1) % 1440) / 60) * 256 + ((m_tod / 60 + 1) % 1440) % 60));
      wr(1, 16'h000F);
      for (int i = 0; i < 3000; i++) begin
         r   = int'($urandom_range(0, 999));
         ctl = 16'({m_ialarm, m_isec, m_aen, m_run});
         if (r < 600) tk();
         else if (r < 750) rd(int'($urandom_range(0, 7)));
         else if (r < 780) wr(1, ctl | 16'h0010);
         else if (r < 800) wr(0, 16'h0001);
         else if (r < 815) cyc(bit'($urandom_range(0, 1)), 1, 0, 3, 16'($urandom_range(0, 63)));
         else if (r < 830) wr(0, 16'h0002);
         else if (r < 840) begin
            a = (m_tod / 60 + int'($urandom_range(0, 1))) % 1440;
            wr(4, 16'((a / 60) * 256 + a % 60));
         end else if (r < 845) wr(1, 16'({$urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 4) != 0), 1'b1}));
         else if (r < 848) wr(2, 16'($urandom_range(0, 65535)));
         else cyc(0, 0, 1, 0, 16'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
